writeback_stage: RTL and testbench

//  Parametrised RISC-V writeback stage. Accepts MEM/WB bundles over a valid/ready handshake

---
 rtl/wb_pkg.sv | 37 +++
 rtl/load_extend.sv | 38 +++
 rtl/writeback_stage.sv | 176 +++++++++++++++++
 tb/tb_writeback_stage.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source and load-size encodings,
// the control half of a buffered MEM/WB bundle, and the load-size clamp helper.
package wb_pkg;

  localparam int WB_DEFAULT_REG_WIDTH  = 32;
  localparam int WB_DEFAULT_REG_COUNT  = 32;
  localparam int WB_DEFAULT_FIFO_DEPTH = 2;
  localparam int WB_DEFAULT_CNT_WIDTH  = 64;

  typedef enum logic [1:0] {
    WB_ALU    = 2'd0,
    WB_MEM    = 2'd1,
    WB_PC_RET = 2'd2,
    WB_AUX    = 2'd3
  } wb_src_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  // Width-independent part of a bundle; the data fields are sized by the top.
  typedef struct packed {
    logic     wen;
    wb_src_e  src;
    ld_size_e size;
    logic     is_unsigned;
  } wb_ctrl_t;

  // A doubleword load on a 32-bit datapath behaves as a word load.
  function automatic ld_size_e clamp_size(input ld_size_e size, input int reg_width);
    return ((size == LD_D) && (reg_width < 64)) ? LD_W : size;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data extraction: shift the aligned memory word down to the addressed byte,
// keep 8/16/32/64 bits and sign- or zero-extend to the datapath width.
module load_extend
  import wb_pkg::*;
#(
  parameter int  REG_WIDTH = WB_DEFAULT_REG_WIDTH,
  localparam int OFF_BITS  = $clog2(REG_WIDTH / 8)
) (
  input  logic [REG_WIDTH-1:0] mem_word,
  input  logic [OFF_BITS-1:0]  offset,
  input  ld_size_e             size,
  input  logic                 is_unsigned,
  output logic [REG_WIDTH-1:0] data
);

  logic [REG_WIDTH-1:0] shifted;
  logic [REG_WIDTH-1:0] mask;
  logic [REG_WIDTH-1:0] sign_bit;
  logic                 negative;

  // NOTE: every variable gets a default at the top of the block so no path
  // through the case leaves it unassigned, which would infer a latch.
  always_comb begin
    shifted  = mem_word >> {offset, 3'b000};
    mask     = '1;
    unique case (clamp_size(size, REG_WIDTH))
      LD_B:    mask = REG_WIDTH'(8'hFF);
      LD_H:    mask = REG_WIDTH'(16'hFFFF);
      LD_W:    mask = REG_WIDTH'(32'hFFFF_FFFF);
      default: mask = '1;
    endcase
    // The highest set bit of the mask marks the sign position of the loaded value.
    sign_bit = mask & ~(mask >> 1);
    negative = !is_unsigned && |(shifted & sign_bit);
    data     = (shifted & mask) | (negative ? ~mask : '0);
  end

endmodule

// File: rtl/writeback_stage.sv
// RISC-V writeback stage: buffers MEM/WB bundles in a small FIFO, selects and
// extends the result at the head, registers one register-file write per cycle.
module writeback_stage
  import wb_pkg::*;
#(
  parameter int  REG_WIDTH  = WB_DEFAULT_REG_WIDTH,
  parameter int  REG_COUNT  = WB_DEFAULT_REG_COUNT,
  parameter int  FIFO_DEPTH = WB_DEFAULT_FIFO_DEPTH,
  parameter int  CNT_WIDTH  = WB_DEFAULT_CNT_WIDTH,
  localparam int REG_BITS   = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_wen,
  input  logic [REG_BITS-1:0]  in_rd,
  input  logic [REG_WIDTH-1:0] in_alu,
  input  logic [REG_WIDTH-1:0] in_mem,
  input  logic [REG_WIDTH-1:0] in_pc_ret,
  input  logic [REG_WIDTH-1:0] in_aux,
  input  logic [1:0]           in_src,
  input  logic [1:0]           in_size,
  input  logic                 in_unsigned,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 write_en,
  output logic [REG_BITS-1:0]  write_reg,
  output logic [REG_WIDTH-1:0] write_data,
  output logic                 fwd_valid,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam int PTR_BITS = $clog2(FIFO_DEPTH);
  localparam int OCC_BITS = PTR_BITS + 1;
  localparam int OFF_BITS = $clog2(REG_WIDTH / 8);

  typedef struct packed {
    wb_ctrl_t             ctrl;
    logic [REG_BITS-1:0]  rd;
    logic [REG_WIDTH-1:0] alu;
    logic [REG_WIDTH-1:0] mem;
    logic [REG_WIDTH-1:0] pc_ret;
    logic [REG_WIDTH-1:0] aux;
  } wb_entry_t;

  wb_entry_t            fifo_q [FIFO_DEPTH];
  wb_entry_t            in_entry;
  wb_entry_t            head;

  logic [PTR_BITS-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_BITS-1:0]  count_q, count_d;
  logic                 write_en_q, write_en_d;
  logic [REG_BITS-1:0]  write_reg_q, write_reg_d;
  logic [REG_WIDTH-1:0] write_data_q, write_data_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;

  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;
  logic [REG_WIDTH-1:0] ld_data;
  logic [REG_WIDTH-1:0] result;

  assign full     = (count_q == OCC_BITS'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign in_ready = !full;
  // Flush outranks both the incoming bundle and a pending commit.
  assign push     = in_valid && !full && !flush;
  assign pop      = !empty && !stall && !flush;

  always_comb begin
    in_entry.ctrl.wen         = in_wen;
    in_entry.ctrl.src         = wb_src_e'(in_src);
    in_entry.ctrl.size        = ld_size_e'(in_size);
    in_entry.ctrl.is_unsigned = in_unsigned;
    in_entry.rd               = in_rd;
    in_entry.alu              = in_alu;
    in_entry.mem              = in_mem;
    in_entry.pc_ret           = in_pc_ret;
    in_entry.aux              = in_aux;
  end

  assign head = fifo_q[rd_ptr_q];

  load_extend #(
    .REG_WIDTH (REG_WIDTH)
  ) u_load_extend (
    .mem_word    (head.mem),
    .offset      (head.alu[OFF_BITS-1:0]),
    .size        (head.ctrl.size),
    .is_unsigned (head.ctrl.is_unsigned),
    .data        (ld_data)
  );

  always_comb begin
    result = head.alu;
    unique case (head.ctrl.src)
      WB_ALU:    result = head.alu;
      WB_MEM:    result = ld_data;
      WB_PC_RET: result = head.pc_ret;
      WB_AUX:    result = head.aux;
      default:   result = head.alu;
    endcase
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    write_en_d   = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    retired_d    = retired_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_BITS'(1);
      end
      if (pop) begin
        rd_ptr_d     = rd_ptr_q + PTR_BITS'(1);
        write_en_d   = head.ctrl.wen && (head.rd != '0);
        write_reg_d  = head.rd;
        write_data_d = result;
        retired_d    = retired_q + CNT_WIDTH'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + OCC_BITS'(1);
        2'b01:   count_d = count_q - OCC_BITS'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_en_q   <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      retired_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      write_en_q   <= write_en_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      retired_q    <= retired_d;
    end
  end

  // NOTE: the entry storage has no reset; occupancy alone decides which slots
  // are meaningful, so resetting the array would only cost flops and routing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= in_entry;
    end
  end

  assign write_en   = write_en_q;
  assign write_reg  = write_reg_q;
  assign write_data = write_data_q;
  assign fwd_valid  = write_en_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Self-checking bench for writeback_stage: directed scenarios plus randomized
// traffic compared against a queue-based reference model of the stage.
module tb_writeback_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [4:0]  in_rd;
  logic [31:0] in_alu;
  logic [31:0] in_mem;
  logic [31:0] in_pc_ret;
  logic [31:0] in_aux;
  logic [1:0]  in_src;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic        stall;
  logic        flush;
  logic        write_en;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        fwd_valid;
  logic [63:0] retired;

  writeback_stage #(
    .REG_WIDTH  (32),
    .REG_COUNT  (32),
    .FIFO_DEPTH (DEPTH),
    .CNT_WIDTH  (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_wen      (in_wen),
    .in_rd       (in_rd),
    .in_alu      (in_alu),
    .in_mem      (in_mem),
    .in_pc_ret   (in_pc_ret),
    .in_aux      (in_aux),
    .in_src      (in_src),
    .in_size     (in_size),
    .in_unsigned (in_unsigned),
    .stall       (stall),
    .flush       (flush),
    .write_en    (write_en),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .fwd_valid   (fwd_valid),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  rd;
    logic [1:0]  src;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [31:0] aux;
    logic [1:0]  size;
    logic        uns;
  } ent_t;

  ent_t            model_q[$];
  logic            exp_we;
  logic [4:0]      exp_reg;
  logic [31:0]     exp_data;
  longint unsigned exp_ret;
  int              n_tests = 0;
  int              n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference value from the bundle: byte-lane arithmetic on the memory word.
  function automatic logic [31:0] ref_value(input ent_t e);
    longint unsigned w;
    longint unsigned span;
    int nbytes;
    case (e.src)
      2'd0: return e.alu;
      2'd2: return e.pc;
      2'd3: return e.aux;
      default: begin
        nbytes = (e.size == 2'd0) ? 1 : (e.size == 2'd1) ? 2 : 4;
        w      = longint'(e.mem) >> (8 * int'(e.alu[1:0]));
        span   = 64'd1 << (8 * nbytes);
        w      = w % span;
        if (!e.uns && (w >= span / 2)) w = w + (64'h1_0000_0000 - span);
        return w[31:0];
      end
    endcase
  endfunction

  task automatic drive(input logic v, input logic wen, input logic [4:0] rd,
                       input logic [1:0] src, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [1:0] size, input logic uns);
    in_valid    = v;
    in_wen      = wen;
    in_rd       = rd;
    in_src      = src;
    in_alu      = alu;
    in_mem      = mem;
    in_pc_ret   = alu + 32'd4;
    in_aux      = ~alu;
    in_size     = size;
    in_unsigned = uns;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 2'd0, 1'b0);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_we   = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
    exp_ret  = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_write_en"},   64'(write_en),   64'(exp_we));
    check({tag, "_fwd_valid"},  64'(fwd_valid),  64'(exp_we));
    check({tag, "_write_reg"},  64'(write_reg),  64'(exp_reg));
    check({tag, "_write_data"}, 64'(write_data), 64'(exp_data));
    check({tag, "_retired"},    retired,         exp_ret);
  endtask

  // One clock: check readiness before the edge, advance the model, check outputs after.
  task automatic step(input string tag);
    ent_t cur;
    ent_t e;
    bit   rdy;
    rdy = (model_q.size() < DEPTH);
    check({tag, "_in_ready"}, 64'(in_ready), 64'(rdy));
    cur = '{wen: in_wen, rd: in_rd, src: in_src, alu: in_alu, mem: in_mem,
            pc: in_pc_ret, aux: in_aux, size: in_size, uns: in_unsigned};
    @(posedge clk);
    if (flush) begin
      model_q.delete();
      exp_we = 1'b0;
    end else begin
      if (model_q.size() > 0 && !stall) begin
        e        = model_q.pop_front();
        exp_we   = e.wen && (e.rd != 5'd0);
        exp_reg  = e.rd;
        exp_data = ref_value(e);
        exp_ret++;
      end else begin
        exp_we = 1'b0;
      end
      if (in_valid && rdy) model_q.push_back(cur);
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs("reset");
    check("reset_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // Scenario 1: plain ALU write, visible after the second edge.
    drive(1'b1, 1'b1, 5'd5, 2'd0, 32'h1234, 32'd0, 2'd2, 1'b0);
    step("s1_push");
    idle();
    step("s1_commit");
    check("s1_we",   64'(write_en),   64'd1);
    check("s1_reg",  64'(write_reg),  64'd5);
    check("s1_data", 64'(write_data), 64'h1234);
    check("s1_ret",  retired,         64'd1);

    // Scenario 2: LB signed, LB unsigned, LH, back to back.
    drive(1'b1, 1'b1, 5'd7, 2'd1, 32'h1002, 32'h80FF7F01, 2'd0, 1'b0);
    step("s2_lb");
    drive(1'b1, 1'b1, 5'd8, 2'd1, 32'h1002, 32'h80FF7F01, 2'd0, 1'b1);
    step("s2_lbu");
    check("s2_lb_data", 64'(write_data), 64'hFFFFFFFF);
    drive(1'b1, 1'b1, 5'd9, 2'd1, 32'h1002, 32'h80FF7F01, 2'd1, 1'b0);
    step("s2_lh");
    check("s2_lbu_data", 64'(write_data), 64'h000000FF);
    idle();
    step("s2_drain");
    check("s2_lh_data", 64'(write_data), 64'hFFFF80FF);

    // Scenario 3: rd=x0 retires without a write strobe.
    drive(1'b1, 1'b1, 5'd0, 2'd3, 32'h55, 32'd0, 2'd0, 1'b0);
    step("s3_push");
    idle();
    step("s3_commit");
    check("s3_we",  64'(write_en), 64'd0);
    check("s3_ret", retired,       64'd5);

    // Scenario 4: fill under stall, then drain in order.
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd10, 2'd0, 32'hA0, 32'd0, 2'd0, 1'b0);
    step("s4_push0");
    drive(1'b1, 1'b1, 5'd11, 2'd2, 32'hB0, 32'd0, 2'd0, 1'b0);
    step("s4_push1");
    check("s4_full", 64'(in_ready), 64'd0);
    idle();
    stall = 1'b0;
    step("s4_pop0");
    check("s4_ready_after_pop", 64'(in_ready), 64'd1);
    step("s4_pop1");
    check("s4_second_data", 64'(write_data), 64'hB4);

    // Scenario 5: flush two buffered entries while a new bundle is offered.
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd12, 2'd0, 32'hC0, 32'd0, 2'd0, 1'b0);
    step("s5_push0");
    drive(1'b1, 1'b1, 5'd13, 2'd0, 32'hD0, 32'd0, 2'd0, 1'b0);
    step("s5_push1");
    drive(1'b1, 1'b1, 5'd14, 2'd0, 32'hE0, 32'd0, 2'd0, 1'b0);
    flush = 1'b1;
    step("s5_flush");
    flush = 1'b0;
    stall = 1'b0;
    idle();
    step("s5_after0");
    step("s5_after1");
    check("s5_we",  64'(write_en), 64'd0);
    check("s5_ret", retired,       64'd7);

    // Scenario 6: asynchronous reset with one entry buffered.
    stall = 1'b1;
    drive(1'b1, 1'b1, 5'd3, 2'd0, 32'hF0, 32'd0, 2'd0, 1'b0);
    step("s6_push");
    idle();
    #2 rst = 1'b1;
    #1;
    check("s6_we",       64'(write_en), 64'd0);
    check("s6_in_ready", 64'(in_ready), 64'd1);
    check("s6_retired",  retired,       64'd0);
    model_reset();
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    step("s6_after");

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  src;
      logic [1:0]  size;
      logic [31:0] alu;
      src  = 2'($urandom_range(0, 3));
      size = 2'($urandom_range(0, 3));
      alu  = $urandom;
      if (src == 2'd1) begin
        if (size == 2'd1)      alu[0]   = 1'b0;
        else if (size >= 2'd2) alu[1:0] = 2'b00;
      end
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 31) < 4 ? 0 : $urandom_range(1, 31)),
            src, alu, $urandom, size, 1'($urandom));
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    stall = 1'b0;
    flush = 1'b0;
    idle();
    repeat (3) step("rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
